// File: rtl/cpu_move_picker.sv
// Computer move picker for a 3x3 board: random (row, col) attempts from the
// LFSR stream, then a deterministic linear scan, reporting no_move on a full board.
module cpu_move_picker #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] random,
  input  logic [8:0] occupied,
  output logic       busy,
  output logic       done,
  output logic [1:0] move_row,
  output logic [1:0] move_col,
  output logic [3:0] move_idx,
  output logic       no_move,
  output logic [3:0] tries
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_CHECK,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_TRIES_4 = 4'(MAX_TRIES);
  localparam logic [8:0] FULL_BOARD  = 9'h1FF;

  state_t     state;
  state_t     state_next;
  logic [1:0] row_reg;
  logic [1:0] col_reg;
  logic [3:0] scan_idx;
  logic [3:0] check_idx;
  logic [3:0] tries_inc;
  logic       check_free;
  logic       scan_free;

  // The LFSR never produces 0, but a stray 0 is folded onto index 1.
  function automatic logic [1:0] sanitize(input logic [1:0] r);
    return (r == 2'd0) ? 2'd1 : r;
  endfunction

  function automatic logic [1:0] idx_row(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: idx_row = 2'd1;
      4'd3, 4'd4, 4'd5: idx_row = 2'd2;
      default:          idx_row = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] i);
    case (i)
      4'd0, 4'd3, 4'd6: idx_col = 2'd1;
      4'd1, 4'd4, 4'd7: idx_col = 2'd2;
      default:          idx_col = 2'd3;
    endcase
  endfunction

  assign check_idx  = ({2'b00, row_reg} - 4'd1) * 4'd3 + ({2'b00, col_reg} - 4'd1);
  assign tries_inc  = tries + 4'd1;
  assign check_free = ~occupied[check_idx];
  assign scan_free  = ~occupied[scan_idx];

  assign busy = (state == S_ROW) || (state == S_COL) ||
                (state == S_CHECK) || (state == S_SCAN);
  assign done = (state == S_DONE);

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; an incomplete assignment in always_comb would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (occupied == FULL_BOARD) ? S_DONE : S_ROW;
      S_ROW:   state_next = S_COL;
      S_COL:   state_next = S_CHECK;
      S_CHECK: begin
        if (check_free)                  state_next = S_DONE;
        else if (tries_inc == MAX_TRIES_4) state_next = S_SCAN;
        else                             state_next = S_ROW;
      end
      S_SCAN:  if (scan_free || scan_idx == 4'd8) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg  <= 2'd0;
      col_reg  <= 2'd0;
      scan_idx <= 4'd0;
      move_row <= 2'd0;
      move_col <= 2'd0;
      move_idx <= 4'd0;
      no_move  <= 1'b0;
      tries    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (occupied == FULL_BOARD) begin
              no_move <= 1'b1;
            end else begin
              no_move <= 1'b0;
              tries   <= 4'd0;
            end
          end
        end
        S_ROW: row_reg <= sanitize(random);
        S_COL: col_reg <= sanitize(random);
        S_CHECK: begin
          if (check_free) begin
            move_row <= row_reg;
            move_col <= col_reg;
            move_idx <= check_idx;
          end else begin
            tries    <= tries_inc;
            scan_idx <= 4'd0;
          end
        end
        S_SCAN: begin
          if (scan_free) begin
            move_idx <= scan_idx;
            move_row <= idx_row(scan_idx);
            move_col <= idx_col(scan_idx);
          end else if (scan_idx == 4'd8) begin
            no_move <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_move_picker.sv
// Directed bench for cpu_move_picker: reset, first-try hit, collision retry,
// scan fallback, full board, ignored start and mid-request reset.
module tb_cpu_move_picker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] random;
  logic [8:0] occupied;
  logic       busy;
  logic       done;
  logic [1:0] move_row;
  logic [1:0] move_col;
  logic [3:0] move_idx;
  logic       no_move;
  logic [3:0] tries;

  int total = 0;
  int bad   = 0;

  cpu_move_picker #(.MAX_TRIES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .random   (random),
    .occupied (occupied),
    .busy     (busy),
    .done     (done),
    .move_row (move_row),
    .move_col (move_col),
    .move_idx (move_idx),
    .no_move  (no_move),
    .tries    (tries)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set after this are sampled next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; random = 2'd1; occupied = 9'h000;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({busy, done, move_row, move_col, move_idx, no_move, tries} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b row=%0d col=%0d idx=%0d no_move=%b tries=%0d, want all 0",
               busy, done, move_row, move_col, move_idx, no_move, tries);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: cycle %0d got done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_first_hit();
    occupied = 9'h000;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL hit_busy: got %b want 1", busy);
    end
    random = 2'd2; tick();
    random = 2'd3; tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL hit_early_done: got %b want 0", done);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL hit_done_cycle4: got done=%b busy=%b want 1 0", done, busy);
    end
    total++;
    if ({move_row, move_col, move_idx, no_move, tries} !== {2'd2, 2'd3, 4'd5, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL hit_result: got row=%0d col=%0d idx=%0d no_move=%b tries=%0d want 2 3 5 0 0",
               move_row, move_col, move_idx, no_move, tries);
    end
    tick();
    total++;
    if (done !== 1'b0 || move_idx !== 4'd5 || move_row !== 2'd2) begin
      bad++; $display("FAIL hit_hold: got done=%b idx=%0d row=%0d want 0 5 2", done, move_idx, move_row);
    end
  endtask

  task automatic test_collision();
    int n;
    occupied = 9'h001;
    start = 1'b1; tick(); start = 1'b0; n = 1;
    random = 2'd1; tick(); n++;
    random = 2'd1; tick(); n++;
    tick(); n++;
    random = 2'd3; tick(); n++;
    random = 2'd1; tick(); n++;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL coll_early_done: got %b want 0 at cycle %0d", done, n);
    end
    tick(); n++;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL coll_done_cycle7: got done=%b at cycle %0d want 1", done, n);
    end
    total++;
    if ({move_row, move_col, move_idx, tries} !== {2'd3, 2'd1, 4'd6, 4'd1}) begin
      bad++;
      $display("FAIL coll_result: got row=%0d col=%0d idx=%0d tries=%0d want 3 1 6 1",
               move_row, move_col, move_idx, tries);
    end
    tick();
  endtask

  task automatic test_scan();
    int n;
    occupied = 9'h0FF; random = 2'd1;
    start = 1'b1; tick(); start = 1'b0; n = 1;
    while (done !== 1'b1 && n < 100) begin
      tick(); n++;
    end
    total++;
    if (n !== 34) begin
      bad++; $display("FAIL scan_latency: got %0d cycles want 34", n);
    end
    total++;
    if ({move_row, move_col, move_idx, no_move, tries} !== {2'd3, 2'd3, 4'd8, 1'b0, 4'd8}) begin
      bad++;
      $display("FAIL scan_result: got row=%0d col=%0d idx=%0d no_move=%b tries=%0d want 3 3 8 0 8",
               move_row, move_col, move_idx, no_move, tries);
    end
    tick();
  endtask

  task automatic test_full_board();
    occupied = 9'h1FF;
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (done !== 1'b1 || no_move !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL full_done: got done=%b no_move=%b busy=%b want 1 1 0", done, no_move, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || no_move !== 1'b1) begin
      bad++; $display("FAIL full_after: got done=%b busy=%b no_move=%b want 0 0 1", done, busy, no_move);
    end
  endtask

  task automatic test_abort_ignore();
    // Second start while busy is ignored; random=0 in ROW maps to row 1.
    occupied = 9'h000;
    start = 1'b1; tick();
    random = 2'd0; tick();
    random = 2'd2; tick();
    tick();
    total++;
    if (done !== 1'b1 || {move_row, move_col, move_idx, no_move} !== {2'd1, 2'd2, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL ignore_result: got done=%b row=%0d col=%0d idx=%0d no_move=%b want 1 1 2 1 0",
               done, move_row, move_col, move_idx, no_move);
    end
    // start still high during DONE: not accepted, so the next cycle is IDLE.
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ignore_at_done: got busy=%b done=%b want 0 0", busy, done);
    end
    // Reset while in COL aborts with no done pulse.
    start = 1'b1; tick(); start = 1'b0;
    random = 2'd3; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({busy, done, move_row, move_col, move_idx, no_move, tries} !== 15'd0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b row=%0d col=%0d idx=%0d no_move=%b tries=%0d want all 0",
               busy, done, move_row, move_col, move_idx, no_move, tries);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_quiet: cycle %0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_collision();
    test_scan();
    test_full_board();
    test_abort_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
